// File: rtl/seg7_scan_controller.sv
// Seven-segment scan controller.
// Shares one external decoder across NUM_DIGITS digits. The value to show
// is double-buffered: a producer fills the pending buffer through a
// valid/ready handshake, and the pending value is copied into the active
// buffer only at a frame boundary, so a frame never mixes two values.
// A blank gap before every digit lets the decoder settle and avoids ghosting.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_BLANK | all digits off; dec_decimal_o already holds digit idx code
//   ST_SHOW  | digit idx enabled; decoder pattern gated onto seg_out_o
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] load_bcd_i,
  input  logic                    lz_suppress_i,
  output logic [3:0]              dec_decimal_o,
  input  logic [6:0]              dec_display_i,
  output logic [6:0]              seg_out_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    frame_done_o
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_full_q, pending_full_d;
  logic [3:0]              dec_q, dec_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    frame_end;
  logic                    load_accept;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run;
  logic                    digit_blank;

  // State and datapath registers; reset aborts the scan and drops any pending value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_BLANK;
      idx_q          <= '0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      dec_q          <= '0;
      digit_en_q     <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      dec_q          <= dec_d;
      digit_en_q     <= digit_en_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next-state: scan sequencing, load handshake and frame-boundary buffer swap.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    frame_end      = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_TC) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_TC) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    load_accept = load_valid_i && !pending_full_q;

    // Swap first: a load on the boundary edge (pending empty) must wait a frame.
    if (frame_end && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    if (load_accept) begin
      pending_d      = load_bcd_i;
      pending_full_d = 1'b1;
    end

    // Output registers follow the next state so they line up with it.
    dec_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) dec_d = active_d[4*k +: 4];
    end

    digit_en_d = '0;
    if (state_d == ST_SHOW) digit_en_d[idx_d] = 1'b1;

    frame_done_d = frame_end;
  end

  // Leading-zero map: digit k blanks when it and every digit above it are zero.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (active_q[4*k +: 4] == 4'd0);
      lz_blank[k] = zero_run && (k != 0);
    end
  end

  assign digit_blank   = lz_suppress_i && lz_blank[idx_q];
  assign seg_out_o     = ((state_q == ST_SHOW) && !digit_blank) ? dec_display_i : 7'd0;
  assign load_ready_o  = !pending_full_q;
  assign dec_decimal_o = dec_q;
  assign digit_en_o    = digit_en_q;
  assign frame_done_o  = frame_done_q;

endmodule
